// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package servo_pkg;

    // Angle code width and the highest legal code; codes never wrap.
    localparam int                 ANG_W   = 2;
    localparam logic [ANG_W-1:0]   ANG_MAX = ANG_W'(3);

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    // One code toward the target, saturating at the target itself.
    function automatic logic [ANG_W-1:0] step_toward(input logic [ANG_W-1:0] cur,
                                                     input logic [ANG_W-1:0] tgt);
        if (tgt > cur)
            step_toward = cur + ANG_W'(1);
        else if (tgt < cur)
            step_toward = cur - ANG_W'(1);
        else
            step_toward = cur;
    endfunction

endpackage

// File: rtl/servo_cmd_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debouncer, press-event pulse, optional auto-repeat.
// Latency: event 2 sync cycles + DEB_CYCLES after the raw line settles high.
// Backpressure: none; o_evt is a one-cycle pulse that must be consumed when seen.
//
// Ports:
//   i_clk   - core clock
//   i_rst_n - asynchronous active-low reset
//   i_btn   - raw asynchronous button line, 1 = pressed
//   o_evt   - one-cycle press event (plus repeats while held when SERVO_CMD_REPEAT_EN is defined)
//
// Build option: SERVO_CMD_REPEAT_EN adds auto-repeat every REPEAT_CYCLES while held.
module btn_debounce #(
    parameter int DEB_CYCLES    = 20000
`ifdef SERVO_CMD_REPEAT_EN
   ,parameter int REPEAT_CYCLES = 200000
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_evt
);

    localparam int DW = $clog2(DEB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_q;
    logic [DW-1:0] r_deb_cnt;
    logic          w_rise;

    // Only the 0->1 edge of the debounced level is an event; release is silent.
    assign w_rise = r_deb & ~r_deb_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_q   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            // Count consecutive cycles of disagreement; any agreement restarts the count.
            if (r_sync2 != r_deb) begin
                if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DW'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

`ifdef SERVO_CMD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] r_rep_cnt;
    logic          w_rep;

    // Counter restarts on every event, so repeats land every REPEAT_CYCLES after the press.
    assign w_rep = r_deb & r_deb_q & (r_rep_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_cnt <= '0;
        end else if (!r_deb || w_rise || w_rep) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
        end
    end

    assign o_evt = w_rise | w_rep;
`else
    assign o_evt = w_rise;
`endif

endmodule

// File: rtl/servo_cmd.sv
// Keypad-driven servo angle commander: up/down presses move a target, ANG slews one code per step.
// Latency: target updates one cycle after a press event; ANG steps every STEP_CYCLES while slewing.
// Backpressure: none; presses at a range end are dropped and flagged on LIMIT.
//
// Ports:
//   CLK     - core clock
//   reset_n - asynchronous active-low reset
//   BTN_UP  - raw up button, 1 = pressed
//   BTN_DN  - raw down button, 1 = pressed
//   ANG     - registered angle code 0..3 for the PWM stage
//   BUSY    - high while ANG is slewing toward the target
//   LIMIT   - one-cycle pulse when a press is rejected at 0 or ANG_MAX
//
// Build option: SERVO_CMD_REPEAT_EN enables button auto-repeat (REPEAT_CYCLES period).
module servo_cmd
    import servo_pkg::*;
#(
    parameter int DEB_CYCLES    = 20000,
    parameter int STEP_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 200000
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    output logic [ANG_W-1:0] ANG,
    output logic             BUSY,
    output logic             LIMIT
);

    localparam int SW = $clog2(STEP_CYCLES);

    if (DEB_CYCLES < 2 || STEP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_chk
        $error("servo_cmd: DEB_CYCLES, STEP_CYCLES and REPEAT_CYCLES must all be >= 2");
    end

    logic             w_up_evt;
    logic             w_dn_evt;
    logic [ANG_W-1:0] w_ang_nxt;

    state_t           r_state;
    logic [ANG_W-1:0] r_ang;
    logic [ANG_W-1:0] r_tgt;
    logic [SW-1:0]    r_step_cnt;
    logic             r_limit;

    btn_debounce #(
        .DEB_CYCLES    (DEB_CYCLES)
`ifdef SERVO_CMD_REPEAT_EN
       ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_dbn_up (
        .i_clk   (CLK),
        .i_rst_n (reset_n),
        .i_btn   (BTN_UP),
        .o_evt   (w_up_evt)
    );

    btn_debounce #(
        .DEB_CYCLES    (DEB_CYCLES)
`ifdef SERVO_CMD_REPEAT_EN
       ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_dbn_dn (
        .i_clk   (CLK),
        .i_rst_n (reset_n),
        .i_btn   (BTN_DN),
        .o_evt   (w_dn_evt)
    );

    // Target register. Coincident up+down events cancel: no move and no LIMIT.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt   <= '0;
            r_limit <= 1'b0;
        end else begin
            r_limit <= 1'b0;
            if (w_up_evt && !w_dn_evt) begin
                if (r_tgt == ANG_MAX)
                    r_limit <= 1'b1;
                else
                    r_tgt <= r_tgt + ANG_W'(1);
            end else if (w_dn_evt && !w_up_evt) begin
                if (r_tgt == '0)
                    r_limit <= 1'b1;
                else
                    r_tgt <= r_tgt - ANG_W'(1);
            end
        end
    end

    // Direction comes from the live target at each step, so retargeting mid-move
    // bends the trajectory without restarting the step timer.
    assign w_ang_nxt = step_toward(r_ang, r_tgt);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ang      <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_tgt != r_ang) begin
                        r_state    <= MOVE;
                        r_step_cnt <= '0;
                    end
                end
                MOVE: begin
                    // Target pulled back onto ANG: stop now, the pending step is dropped.
                    if (r_tgt == r_ang) begin
                        r_state    <= IDLE;
                        r_step_cnt <= '0;
                    end else if (r_step_cnt == SW'(STEP_CYCLES - 1)) begin
                        r_ang      <= w_ang_nxt;
                        r_step_cnt <= '0;
                        if (w_ang_nxt == r_tgt)
                            r_state <= IDLE;
                    end else begin
                        r_step_cnt <= r_step_cnt + SW'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_step_cnt <= '0;
                end
            endcase
        end
    end

    assign ANG   = r_ang;
    assign BUSY  = (r_state == MOVE);
    assign LIMIT = r_limit;

endmodule

// File: tb/tb_servo_cmd.sv
// Self-checking bench for servo_cmd with short timing parameters.
// Table of button segments with hand-derived results, corner-case sequences,
// then random button traffic against a behavioural model checked every cycle.
module tb_servo_cmd;

    localparam int DEB  = 4;
    localparam int STEP = 8;
    localparam int REP  = 16;

    logic       CLK;
    logic       reset_n;
    logic       BTN_UP;
    logic       BTN_DN;
    logic [1:0] ANG;
    logic       BUSY;
    logic       LIMIT;

    int checks   = 0;
    int errors   = 0;
    int lim_seen = 0;

    servo_cmd #(
        .DEB_CYCLES    (DEB),
        .STEP_CYCLES   (STEP),
        .REPEAT_CYCLES (REP)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .BTN_UP  (BTN_UP),
        .BTN_DN  (BTN_DN),
        .ANG     (ANG),
        .BUSY    (BUSY),
        .LIMIT   (LIMIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    // Index 0 = up button, 1 = down button.
    bit m_seen1[2];     // raw value one edge ago
    bit m_seen2[2];     // raw value two edges ago (synchronized view)
    bit m_level[2];     // debounced level
    bit m_level_old[2]; // debounced level one cycle earlier
    int m_disagree[2];  // consecutive cycles synchronized view differs from level
    int m_held[2];      // cycles since last event while level is high
    int m_tgt;
    int m_ang;
    int m_elapsed;      // cycles spent slewing since the last step (or start)
    bit m_slewing;
    bit m_lim;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seen1[i] = 0; m_seen2[i] = 0; m_level[i] = 0; m_level_old[i] = 0;
            m_disagree[i] = 0; m_held[i] = 0;
        end
        m_tgt = 0; m_ang = 0; m_elapsed = 0; m_slewing = 0; m_lim = 0;
    endtask

    task automatic model_step(input bit up, input bit dn);
        bit btn[2];
        bit ev[2];
        btn[0] = up;
        btn[1] = dn;
        // Events visible during the cycle just ending.
        for (int i = 0; i < 2; i++) begin
            ev[i] = m_level[i] && !m_level_old[i];
`ifdef SERVO_CMD_REPEAT_EN
            if (m_level[i] && m_held[i] == REP) ev[i] = 1;
`endif
            if (!m_level[i])  m_held[i] = 0;
            else if (ev[i])   m_held[i] = 1;
            else              m_held[i] = m_held[i] + 1;
        end
        // Slew: reads the target as it stood during this cycle.
        if (!m_slewing) begin
            if (m_tgt != m_ang) begin
                m_slewing = 1;
                m_elapsed = 0;
            end
        end else if (m_tgt == m_ang) begin
            m_slewing = 0;
        end else begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == STEP) begin
                m_ang     = (m_tgt > m_ang) ? m_ang + 1 : m_ang - 1;
                m_elapsed = 0;
                if (m_ang == m_tgt) m_slewing = 0;
            end
        end
        // Target and saturation flag.
        m_lim = 0;
        if (ev[0] && !ev[1]) begin
            if (m_tgt == 3) m_lim = 1; else m_tgt = m_tgt + 1;
        end else if (ev[1] && !ev[0]) begin
            if (m_tgt == 0) m_lim = 1; else m_tgt = m_tgt - 1;
        end
        // Debounce, then shift the synchronizer view.
        for (int i = 0; i < 2; i++) begin
            m_level_old[i] = m_level[i];
            if (m_seen2[i] != m_level[i]) begin
                m_disagree[i] = m_disagree[i] + 1;
                if (m_disagree[i] == DEB) begin
                    m_level[i]    = m_seen2[i];
                    m_disagree[i] = 0;
                end
            end else begin
                m_disagree[i] = 0;
            end
            m_seen2[i] = m_seen1[i];
            m_seen1[i] = btn[i];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!reset_n) model_reset();
        else          model_step(BTN_UP, BTN_DN);
        @(negedge CLK);
        check("model_ang",   ANG,   m_ang);
        check("model_busy",  BUSY,  m_slewing);
        check("model_limit", LIMIT, m_lim);
        if (LIMIT === 1'b1) lim_seen++;
    endtask

    task automatic drive(input bit up, input bit dn, input int n);
        BTN_UP   = up;
        BTN_DN   = dn;
        lim_seen = 0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_ang",   ANG,   0);
        check("rst_busy",  BUSY,  0);
        check("rst_limit", LIMIT, 0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit up;
        bit dn;
        int len;
        int ang;
        bit busy;
        int lim;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        // {up, dn, cycles, ANG at end, BUSY at end, LIMIT pulses in segment}
        vecs[0]  = '{1, 0, 10, 0, 1, 0};
        vecs[1]  = '{0, 0, 10, 1, 0, 0};
        vecs[2]  = '{1, 0, 10, 1, 1, 0};
        vecs[3]  = '{0, 0, 10, 2, 0, 0};
        vecs[4]  = '{1, 0, 10, 2, 1, 0};
        vecs[5]  = '{0, 0, 10, 3, 0, 0};
        vecs[6]  = '{1, 0, 10, 3, 0, 1};
        vecs[7]  = '{0, 0, 10, 3, 0, 0};
        vecs[8]  = '{0, 1, 10, 3, 1, 0};
        vecs[9]  = '{0, 0, 10, 2, 0, 0};
        vecs[10] = '{1, 1, 10, 2, 0, 0};
        vecs[11] = '{0, 0, 10, 2, 0, 0};
        vecs[12] = '{0, 1, 10, 2, 1, 0};
        vecs[13] = '{0, 0, 10, 1, 0, 0};
        vecs[14] = '{0, 1, 10, 1, 1, 0};
        vecs[15] = '{0, 0, 10, 0, 0, 0};
        vecs[16] = '{0, 1, 10, 0, 0, 1};
        vecs[17] = '{0, 0, 10, 0, 0, 0};

        BTN_UP  = 1'b0;
        BTN_DN  = 1'b0;
        reset_n = 1'b0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].up, vecs[i].dn, vecs[i].len);
            check($sformatf("vec%0d_ang", i),   ANG,      vecs[i].ang);
            check($sformatf("vec%0d_busy", i),  BUSY,     vecs[i].busy);
            check($sformatf("vec%0d_limit", i), lim_seen, vecs[i].lim);
        end

        // Bouncing press 1-1-0-0 then stable: one event, timed from the last edge.
        drive(1, 0, 2);
        drive(0, 0, 2);
        drive(1, 0, 5);
        check("bounce_no_evt_yet", BUSY, 0);
        drive(1, 0, 1);
        drive(1, 0, 1);
        check("bounce_tgt_slot", BUSY, 0);
        drive(1, 0, 1);
        check("bounce_move", BUSY, 1);
        drive(1, 0, 5);
        drive(0, 0, 20);
        check("bounce_one_evt_ang", ANG, 1);
        check("bounce_one_evt_busy", BUSY, 0);

        // Back to 0, then three quick ups and a down while slewing.
        drive(0, 1, 4);
        drive(0, 0, 20);
        check("home_ang", ANG, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4);
            drive(0, 0, 4);
        end
        check("slew_mid_ang", ANG, 2);
        check("slew_mid_busy", BUSY, 1);
        drive(0, 1, 4);
        drive(0, 0, 4);
        check("retarget_stop_ang", ANG, 2);
        check("retarget_stop_busy", BUSY, 0);
        drive(0, 0, 10);
        check("retarget_hold_ang", ANG, 2);

        // Target overtaken while moving down, then pulled back onto ANG.
        drive(0, 1, 4);
        drive(0, 0, 4);
        drive(0, 1, 4);
        drive(0, 0, 4);
        drive(1, 0, 4);
        drive(0, 0, 2);
        drive(0, 0, 1);
        check("tgt_eq_ang_still_busy", BUSY, 1);
        check("tgt_eq_ang_ang", ANG, 1);
        drive(0, 0, 1);
        check("tgt_eq_ang_idle", BUSY, 0);
        check("tgt_eq_ang_no_step", ANG, 1);

        // Reset mid-move with BTN_UP held through it.
        drive(1, 0, 10);
        check("pre_rst_ang", ANG, 1);
        check("pre_rst_busy", BUSY, 1);
        do_reset();
        drive(1, 0, 10);
        check("held_rst_ang", ANG, 0);
        check("held_rst_busy", BUSY, 1);
        drive(0, 0, 10);
        check("held_rst_one_evt", ANG, 1);
        check("held_rst_idle", BUSY, 0);

        // Long hold: auto-repeat only when built with repeat enabled.
        do_reset();
        drive(1, 0, 60);
`ifdef SERVO_CMD_REPEAT_EN
        check("hold_limit", lim_seen, 1);
`else
        check("hold_limit", lim_seen, 0);
`endif
        drive(0, 0, 40);
`ifdef SERVO_CMD_REPEAT_EN
        check("hold_ang", ANG, 3);
`else
        check("hold_ang", ANG, 1);
`endif
        check("hold_busy", BUSY, 0);

        // Random traffic; short segments act as bounce, long ones as real presses.
        for (int s = 0; s < 200; s++) begin
            bit up;
            bit dn;
            int len;
            up  = ($urandom_range(0, 2) == 0);
            dn  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 20);
            if ($urandom_range(0, 49) == 0) do_reset();
            else                            drive(up, dn, len);
        end
        drive(0, 0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_cmd.md
SERVO_CMD -- requirements
Module: servo_cmd

Interface
REQ-001 Parameter DEB_CYCLES, default 20000, meaning cycles of stable synchronized input before the debounced level changes (>=2).
REQ-002 Parameter STEP_CYCLES, default 50000, meaning cycles between successive one-step moves of ANG (>=2).
REQ-003 Parameter REPEAT_CYCLES, default 200000, meaning auto-repeat period while a button is held (>=2; used only with SERVO_CMD_REPEAT_EN).
REQ-004 CLK  input  1  the single clock; all state updates on posedge CLK.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 BTN_UP  input  1  raw, asynchronous, bouncing keypad line; 1 = pressed.
REQ-007 BTN_DN  input  1  raw, asynchronous, bouncing keypad line; 1 = pressed.
REQ-008 ANG  output  2  angle code for the downstream servo PWM stage; 0..3, registered.
REQ-009 BUSY  output  1  1 while ANG is slewing toward the target.
REQ-010 LIMIT  output  1  one-cycle pulse when a press is rejected by saturation.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level takes the synchronized value once that value has differed from it for DEB_CYCLES consecutive cycles; any reversion clears the counter.
REQ-012 A press event SHALL be a one-cycle pulse on the 0->1 transition of a debounced level; 1->0 produces no event.
REQ-013 Target register tgt (0..3) SHALL update the cycle after an event: up -> tgt+1, down -> tgt-1.
REQ-014 Up at tgt==3 or down at tgt==0 SHALL leave tgt unchanged and pulse LIMIT for exactly one cycle, coincident with the tgt update slot.
REQ-015 Up and down events in the same cycle SHALL both be discarded: no tgt change, no LIMIT.
REQ-016 FSM states IDLE and MOVE; IDLE -> MOVE when tgt!=ANG, clearing step counter.
REQ-017 In MOVE the step counter increments each cycle; at STEP_CYCLES-1 ANG moves one code toward tgt and the counter clears; if ANG then equals tgt, go IDLE.
REQ-018 Direction SHALL be re-evaluated at every step from the current tgt; a tgt change mid-move never restarts the counter.
REQ-019 If tgt becomes equal to ANG while in MOVE, the FSM SHALL return to IDLE the next cycle with no further step.
REQ-020 BUSY SHALL equal (state==MOVE); ANG never changes by more than 1 per step and never wraps 3<->0.

Reset
REQ-021 reset_n low SHALL immediately force ANG=0, tgt=0, BUSY=0, LIMIT=0, state IDLE, all synchronizer, debounce, step and repeat state to 0, including mid-move or mid-debounce.
REQ-022 After reset release a button already held SHALL be debounced from scratch and produce one event.

Configuration
REQ-023 Macro SERVO_CMD_REPEAT_EN defined: a debounced level held 1 for REPEAT_CYCLES cycles after its event SHALL generate a further event, repeating every REPEAT_CYCLES while held; release clears the repeat counter.
REQ-024 Macro undefined: no repeat logic; exactly one event per debounced press; REPEAT_CYCLES ignored.

Structure
REQ-025 Package servo_pkg SHALL hold the ANG width constant (2), ANG_MAX (3) and the FSM state enum (IDLE, MOVE).
REQ-026 Sub-module btn_debounce (synchronizer, debouncer, rising-edge event, optional repeat) SHALL be instantiated once per button.

Verification (DEB_CYCLES=4, STEP_CYCLES=8, REPEAT_CYCLES=16)
REQ-027 Clean BTN_UP pulse held 10 cycles from reset -> one event, tgt=1, BUSY=1, ANG 0->1 after 8 cycles in MOVE, then BUSY=0.
REQ-028 BTN_UP bouncing 1-0-1 with 2-cycle segments then stable 1 -> exactly one event, timed from last transition +4 cycles.
REQ-029 Four up presses spaced 20 cycles -> tgt 1,2,3, fourth gives LIMIT pulse, ANG ends 3 with one step per 8 cycles.
REQ-030 ANG=0 slewing to tgt=3, down press after first step -> tgt=2, ANG stops at 2; down press when ANG=1,tgt=2 -> tgt=1, IDLE next cycle.
REQ-031 Simultaneous up/down events -> tgt unchanged, LIMIT=0; reset_n pulsed mid-move -> all outputs 0 at once.
REQ-032 With SERVO_CMD_REPEAT_EN, BTN_UP held 60 cycles from tgt=0 -> events at press, +16, +32 -> tgt=3; without macro -> tgt=1.
